// File: rtl/axi_read_burst_issuer.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_burst_issuer
// Description : AXI4 read-address generator. Turns one (start address, byte
//               count) request into a train of full-length INCR bursts on AR,
//               throttled by a count of bursts whose last R beat has not yet
//               returned. Pulses ctrl_done once every burst has completed.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                      : single clock for all logic
//   rst                      : asynchronous, active-high reset
//   ctrl_start               : one-cycle request strobe (accepted in IDLE only)
//   ctrl_addr_offset         : start byte address, beat-aligned internally
//   ctrl_xfer_size_in_bytes  : byte count of the request
//   ctrl_done                : one-cycle completion pulse
//   busy                     : high from the cycle after an accepted start
//                              through the ctrl_done cycle
//   m_axi_arvalid/arready    : AR handshake
//   m_axi_araddr/arlen       : burst start address / beats minus one
//   m_axi_rvalid/rready/rlast: R channel, observed to retire bursts
// ============================================================================
module axi_read_burst_issuer #(
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_DATA_WIDTH       = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_MAX_BURST_LENGTH = 64,
    parameter int C_MAX_OUTSTANDING  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic                         ctrl_done,
    output logic                         busy,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                   m_axi_arlen,
    input  logic                         m_axi_rvalid,
    input  logic                         m_axi_rready,
    input  logic                         m_axi_rlast
);

    localparam int C_BPB      = C_DATA_WIDTH / 8;
    localparam int C_BPB_LOG2 = $clog2(C_BPB);
    localparam int C_MBL_LOG2 = $clog2(C_MAX_BURST_LENGTH);
    localparam int C_CNT_W    = $clog2(C_MAX_OUTSTANDING + 1);
    // One extra bit so the ceil() rounding add can never overflow.
    localparam int C_BEAT_W   = C_XFER_SIZE_WIDTH + 1;

    localparam logic [C_BEAT_W-1:0]     C_BPB_M1      = C_BEAT_W'(C_BPB - 1);
    localparam logic [C_BEAT_W-1:0]     C_MBL_M1      = C_BEAT_W'(C_MAX_BURST_LENGTH - 1);
    localparam logic [C_BEAT_W-1:0]     C_ONE         = C_BEAT_W'(1);
    localparam logic [C_BEAT_W-1:0]     C_TWO         = C_BEAT_W'(2);
    localparam logic [C_ADDR_WIDTH-1:0] C_ALIGN_MASK  = ~C_ADDR_WIDTH'(C_BPB - 1);
    localparam logic [C_ADDR_WIDTH-1:0] C_BURST_BYTES = C_ADDR_WIDTH'(C_MAX_BURST_LENGTH * C_BPB);
    localparam logic [7:0]              C_FULL_LEN    = 8'(C_MAX_BURST_LENGTH - 1);
    localparam logic [C_CNT_W-1:0]      C_MAX_OUT     = C_CNT_W'(C_MAX_OUTSTANDING);
    localparam logic [C_CNT_W-1:0]      C_CNT_ONE     = C_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [C_XFER_SIZE_WIDTH-1:0] r_size;
    logic [C_ADDR_WIDTH-1:0]      r_araddr;
    logic [7:0]                   r_arlen;
    logic [7:0]                   r_last_len;
    logic [C_BEAT_W-1:0]          r_bursts_left;
    logic [C_CNT_W-1:0]           r_outstanding;

    logic                         w_arvalid;
    logic                         w_done;
    logic                         w_ar_hs;
    logic                         w_r_last_hs;
    logic                         w_last_burst;
    logic [C_BEAT_W-1:0]          w_beats;
    logic [C_BEAT_W-1:0]          w_bursts;
    logic [7:0]                   w_last_len;

    // Burst geometry, consumed only in CALC while r_size is stable.
    assign w_beats      = ({1'b0, r_size} + C_BPB_M1) >> C_BPB_LOG2;
    assign w_bursts     = (w_beats + C_MBL_M1) >> C_MBL_LOG2;
    assign w_last_len   = 8'((w_beats - C_ONE) & C_MBL_M1);
    assign w_last_burst = (r_bursts_left == C_ONE);
    assign w_ar_hs      = w_arvalid & m_axi_arready;
    assign w_r_last_hs  = m_axi_rvalid & m_axi_rready & m_axi_rlast;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_arvalid    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctrl_start) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_state_next = (r_size == '0) ? S_DRAIN : S_ISSUE;
            end
            S_ISSUE: begin
                // Throttle on the registered count: the count can only rise
                // through our own handshake, so an asserted arvalid stays up.
                w_arvalid = (r_outstanding < C_MAX_OUT);
                if (w_arvalid && m_axi_arready && w_last_burst) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_outstanding == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and AR address/length sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size        <= '0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_last_len    <= '0;
            r_bursts_left <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        r_size   <= ctrl_xfer_size_in_bytes;
                        r_araddr <= ctrl_addr_offset & C_ALIGN_MASK;
                    end
                end
                S_CALC: begin
                    r_bursts_left <= w_bursts;
                    r_last_len    <= w_last_len;
                    r_arlen       <= (w_bursts == C_ONE) ? w_last_len : C_FULL_LEN;
                end
                S_ISSUE: begin
                    // Advance only on a handshake so address/length hold
                    // stable while arvalid waits on arready.
                    if (w_ar_hs && !w_last_burst) begin
                        r_bursts_left <= r_bursts_left - C_ONE;
                        r_araddr      <= r_araddr + C_BURST_BYTES;
                        r_arlen       <= (r_bursts_left == C_TWO) ? r_last_len : C_FULL_LEN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-burst counter: +1 per AR handshake, -1 per last R beat.
    // A stray last beat at zero is dropped rather than wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_ar_hs, w_r_last_hs})
                2'b10: r_outstanding <= r_outstanding + C_CNT_ONE;
                2'b01: begin
                    if (r_outstanding != '0) begin
                        r_outstanding <= r_outstanding - C_CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_axi_arvalid = w_arvalid;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign ctrl_done     = w_done;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_read_burst_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_read_burst_issuer
// Description : Scoreboard bench for axi_read_burst_issuer. Tests push the
//               expected AR bursts; a monitor pops and compares on every AR
//               handshake and checks AR stability under backpressure. A
//               credit-limited responder returns R beats for issued bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_burst_issuer;

    localparam int AW  = 64;
    localparam int DW  = 512;
    localparam int XW  = 32;
    localparam int MBL = 64;
    localparam int MO  = 16;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_start;
    logic [AW-1:0] ctrl_addr_offset;
    logic [XW-1:0] ctrl_xfer_size_in_bytes;
    logic          ctrl_done;
    logic          busy;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid;
    logic          rready;
    logic          rlast;

    ar_t  exp_ar[$];
    int   rq[$];
    int   total = 0;
    int   bad = 0;
    int   hs_count = 0;
    int   credits = 0;
    int   beat = 0;
    int   bursts_done = 0;

    always #5 clk = ~clk;

    axi_read_burst_issuer #(
        .C_ADDR_WIDTH       (AW),
        .C_DATA_WIDTH       (DW),
        .C_XFER_SIZE_WIDTH  (XW),
        .C_MAX_BURST_LENGTH (MBL),
        .C_MAX_OUTSTANDING  (MO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ctrl_start              (ctrl_start),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_done               (ctrl_done),
        .busy                    (busy),
        .m_axi_arvalid           (arvalid),
        .m_axi_arready           (arready),
        .m_axi_araddr            (araddr),
        .m_axi_arlen             (arlen),
        .m_axi_rvalid            (rvalid),
        .m_axi_rready            (rready),
        .m_axi_rlast             (rlast)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic ar_t mk_ar(input logic [63:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // AR monitor / scoreboard (samples on the falling edge)
    // ------------------------------------------------------------------
    logic        prev_pend;
    logic [63:0] prev_addr;
    logic [7:0]  prev_len;
    ar_t         mon_e;

    initial begin
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_len  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("ar_hold_valid", 64'(arvalid), 64'd1);
                    chk("ar_hold_addr", araddr, prev_addr);
                    chk("ar_hold_len", 64'(arlen), 64'(prev_len));
                end
                if (arvalid && arready) begin
                    hs_count++;
                    total++;
                    if (exp_ar.size() == 0) begin
                        bad++;
                        $display("FAIL ar_unexpected: got addr=0x%0h len=%0d, expected no burst", araddr, arlen);
                    end else begin
                        total--;
                        mon_e = exp_ar.pop_front();
                        chk("ar_addr", araddr, mon_e.addr);
                        chk("ar_len", 64'(arlen), 64'(mon_e.len));
                    end
                    rq.push_back(int'(arlen));
                end
                prev_pend = arvalid && !arready;
                prev_addr = araddr;
                prev_len  = arlen;
            end
        end
    end

    // ------------------------------------------------------------------
    // R responder: returns beats of issued bursts while credits remain
    // ------------------------------------------------------------------
    initial begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                beat   = 0;
            end else begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        void'(rq.pop_front());
                        beat = 0;
                        credits--;
                        bursts_done++;
                    end else begin
                        beat++;
                    end
                end
                if (credits > 0 && rq.size() > 0) begin
                    rvalid = 1'b1;
                    rlast  = (beat == rq[0]);
                end else begin
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                end
            end
        end
    end

    // Leaves the bench at #1 in the cycle after the start cycle.
    task automatic do_start(input logic [63:0] a, input logic [31:0] sz);
        @(posedge clk);
        #1;
        ctrl_start              = 1'b1;
        ctrl_addr_offset        = a;
        ctrl_xfer_size_in_bytes = sz;
        @(posedge clk);
        #1;
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (rnd) arready = 1'($urandom_range(0, 1));
            if (ctrl_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(ok), 64'd1);
        if (ok) begin
            chk("done_busy", 64'(busy), 64'd1);
            chk("done_all_ar", 64'(exp_ar.size()), 64'd0);
            chk("done_after_rlast", 64'(rq.size()), 64'd0);
            @(posedge clk);
            #1;
            chk("done_one_cycle", 64'(ctrl_done), 64'd0);
            chk("busy_after_done", 64'(busy), 64'd0);
        end
        arready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  base;
    int  bd;
    bit  got;

    initial begin
        rst                     = 1'b1;
        ctrl_start              = 1'b0;
        ctrl_addr_offset        = '0;
        ctrl_xfer_size_in_bytes = '0;
        arready                 = 1'b1;
        rready                  = 1'b1;
        #1;
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(ctrl_done), 64'd0);
        chk("rst_araddr", araddr, 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_count", 64'(dut.r_outstanding), 64'd0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;

        // Single full burst, first-arvalid latency
        credits = 1000;
        exp_ar.push_back(mk_ar(64'h1000_0040, 8'd63));
        do_start(64'h1000_0040, 32'd4096);
        chk("lat_calc_arvalid", 64'(arvalid), 64'd0);
        chk("lat_calc_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk("lat_issue_arvalid", 64'(arvalid), 64'd1);
        wait_done(1'b0, 500);

        // 129 beats -> 63/63/0
        exp_ar.push_back(mk_ar(64'h0, 8'd63));
        exp_ar.push_back(mk_ar(64'h1000, 8'd63));
        exp_ar.push_back(mk_ar(64'h2000, 8'd0));
        do_start(64'h0, 32'd8256);
        wait_done(1'b0, 800);

        // Unaligned start address and partial final beat: 200 B -> 4 beats
        exp_ar.push_back(mk_ar(64'hF040, 8'd3));
        do_start(64'hF07F, 32'd200);
        wait_done(1'b0, 200);

        // Address wraps past the top of the address space
        exp_ar.push_back(mk_ar(64'hFFFF_FFFF_FFFF_F000, 8'd63));
        exp_ar.push_back(mk_ar(64'h0, 8'd63));
        do_start(64'hFFFF_FFFF_FFFF_F000, 32'd8192);
        wait_done(1'b0, 600);

        // Outstanding throttle
        credits = 0;
        base    = hs_count;
        for (int k = 0; k < 20; k++) exp_ar.push_back(mk_ar(64'h4000_0000 + 64'(k) * 64'h1000, 8'd63));
        do_start(64'h4000_0000, 32'd81920);
        repeat (40) @(posedge clk);
        #1;
        chk("throttle_hs", 64'(hs_count - base), 64'd16);
        chk("throttle_arvalid", 64'(arvalid), 64'd0);
        chk("throttle_count", 64'(dut.r_outstanding), 64'd16);
        @(negedge clk);
        credits = 1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            if (hs_count - base >= 17) break;
        end
        repeat (5) @(posedge clk);
        #2;
        chk("one_more_hs", 64'(hs_count - base), 64'd17);
        chk("one_more_arvalid", 64'(arvalid), 64'd0);
        arready = 1'b0;
        @(negedge clk);
        bd      = bursts_done;
        credits = 2;
        got     = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            if (bursts_done == bd + 1 && rvalid && rlast) begin
                got = 1'b1;
                break;
            end
        end
        chk("simul_rlast_seen", 64'(got), 64'd1);
        chk("pending_count", 64'(dut.r_outstanding), 64'd15);
        chk("pending_arvalid", 64'(arvalid), 64'd1);
        arready = 1'b1;
        @(posedge clk);
        #2;
        chk("simul_count", 64'(dut.r_outstanding), 64'd15);
        chk("simul_hs", 64'(hs_count - base), 64'd18);
        @(posedge clk);
        #2;
        chk("refill_count", 64'(dut.r_outstanding), 64'd16);
        chk("refill_hs", 64'(hs_count - base), 64'd19);
        chk("refill_arvalid", 64'(arvalid), 64'd0);
        @(negedge clk);
        credits = 1000;
        wait_done(1'b0, 3000);

        // Random arready backpressure: 322 beats -> 5 full + arlen 1
        for (int k = 0; k < 6; k++) exp_ar.push_back(mk_ar(64'h2000 + 64'(k) * 64'h1000, (k == 5) ? 8'd1 : 8'd63));
        do_start(64'h2000, 32'd20580);
        wait_done(1'b1, 3000);

        // Size zero: done at start+3, no AR, re-start while busy ignored
        base = hs_count;
        @(posedge clk);
        #1;
        ctrl_start              = 1'b1;
        ctrl_addr_offset        = 64'h1234;
        ctrl_xfer_size_in_bytes = 32'd0;
        chk("z_busy_n0", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("z_busy_n1", 64'(busy), 64'd1);
        chk("z_done_n1", 64'(ctrl_done), 64'd0);
        ctrl_xfer_size_in_bytes = 32'd4096;
        @(posedge clk);
        #1;
        ctrl_start = 1'b0;
        chk("z_busy_n2", 64'(busy), 64'd1);
        chk("z_done_n2", 64'(ctrl_done), 64'd0);
        chk("z_arvalid_n2", 64'(arvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("z_busy_n3", 64'(busy), 64'd1);
        chk("z_done_n3", 64'(ctrl_done), 64'd1);
        chk("z_arvalid_n3", 64'(arvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("z_busy_n4", 64'(busy), 64'd0);
        chk("z_done_n4", 64'(ctrl_done), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("z_busy_after", 64'(busy), 64'd0);
        chk("z_no_ar", 64'(hs_count - base), 64'd0);

        // Reset mid-ISSUE with five bursts outstanding
        credits = 0;
        base    = hs_count;
        for (int k = 0; k < 20; k++) exp_ar.push_back(mk_ar(64'h8000_0000 + 64'(k) * 64'h1000, 8'd63));
        do_start(64'h8000_0000, 32'd81920);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (hs_count - base >= 5) begin
                arready = 1'b0;
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_count", 64'(dut.r_outstanding), 64'd5);
        chk("pre_rst_hs", 64'(hs_count - base), 64'd5);
        chk("pre_rst_arvalid", 64'(arvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_arvalid", 64'(arvalid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(ctrl_done), 64'd0);
        chk("arst_count", 64'(dut.r_outstanding), 64'd0);
        chk("arst_araddr", araddr, 64'd0);
        exp_ar.delete();
        @(posedge clk);
        #2;
        rq.delete();
        repeat (2) @(posedge clk);
        #3;
        rst     = 1'b0;
        arready = 1'b1;
        credits = 1000;
        exp_ar.push_back(mk_ar(64'h9000_0000, 8'd63));
        do_start(64'h9000_0000, 32'd4096);
        wait_done(1'b0, 500);
        chk("final_queue_empty", 64'(exp_ar.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
